// File: rtl/pa_tcipif_nslv_bridge.sv
// pa_tcipif_nslv_bridge: BMU to NUM_SLV-window TCIP slave bridge with protection, alignment and timeout checks
module pa_tcipif_nslv_bridge #(
    parameter int NUM_SLV = 4,
    parameter int WIN_LOG2 = 12,
    parameter int TIMEOUT_W = 8,
    parameter int TIMEOUT_CYC = 255,
    parameter logic [NUM_SLV-1:0] MPRIV_MASK = 4'b0011
) (
    input  logic                    forever_cpuclk,
    input  logic                    cpurst,
    input  logic [31:0]             pad_cpu_tcip_base,
    input  logic                    rtu_yy_xx_dbgon,
    input  logic                    bmu_tcipif_dbus_req,
    input  logic [31:0]             bmu_tcipif_dbus_addr,
    input  logic                    bmu_tcipif_dbus_write,
    input  logic [31:0]             bmu_tcipif_dbus_wdata,
    input  logic [1:0]              bmu_tcipif_dbus_size,
    input  logic                    bmu_tcipif_dbus_supv_mode,
    input  logic                    bmu_tcipif_dbus_acc_deny,
    output logic                    tcipif_bmu_dbus_grnt,
    output logic                    tcipif_bmu_dbus_trans_cmplt,
    output logic                    tcipif_bmu_dbus_acc_err,
    output logic [31:0]             tcipif_bmu_dbus_data,
    output logic [NUM_SLV-1:0]      tcipif_slv_sel,
    output logic [WIN_LOG2-1:0]     tcipif_xx_addr,
    output logic                    tcipif_xx_write,
    output logic [31:0]             tcipif_xx_wdata,
    output logic [1:0]              tcipif_xx_size,
    input  logic [NUM_SLV-1:0]      slv_tcipif_cmplt,
    input  logic [NUM_SLV*32-1:0]   slv_tcipif_rdata
);
    localparam int IDX_W = $clog2(NUM_SLV);
    localparam int NIDX = 2 ** IDX_W;
    localparam logic [31:0] HI_MASK = ~((32'd1 << (WIN_LOG2 + IDX_W)) - 32'd1);
    localparam logic [NIDX-1:0] MASK_EXT = NIDX'(MPRIV_MASK);
    localparam logic [TIMEOUT_W-1:0] TO_VAL = TIMEOUT_W'(TIMEOUT_CYC);

    typedef enum logic [2:0] {IDLE, ERR, SEL, WAIT, RESP} state_t;

    state_t                 state, nxt;
    logic [IDX_W-1:0]       idx, idx_q;
    logic                   hit, misalign, err, done, expire;
    logic [TIMEOUT_W-1:0]   cnt, cnt_inc;
    logic [NIDX-1:0]        cmplt_ext;
    logic [NIDX*32-1:0]     rdata_ext;
    logic [31:0]            rdata_sel;

    assign idx = bmu_tcipif_dbus_addr[WIN_LOG2 +: IDX_W];
    // Window index may exceed NUM_SLV when NUM_SLV is not a power of two; such addresses miss.
    assign hit = (((bmu_tcipif_dbus_addr ^ pad_cpu_tcip_base) & HI_MASK) == 32'd0)
               && (32'(idx) < 32'(NUM_SLV));
    assign misalign = (bmu_tcipif_dbus_size == 2'd1 && bmu_tcipif_dbus_addr[0])
                   || (bmu_tcipif_dbus_size == 2'd2 && bmu_tcipif_dbus_addr[1:0] != 2'd0);
    assign err = bmu_tcipif_dbus_acc_deny || !hit || bmu_tcipif_dbus_size == 2'd3 || misalign
              || (MASK_EXT[idx] && !bmu_tcipif_dbus_supv_mode && !rtu_yy_xx_dbgon);
    assign tcipif_bmu_dbus_grnt = bmu_tcipif_dbus_req && state == IDLE && !cpurst;

    assign cmplt_ext = NIDX'(slv_tcipif_cmplt);
    assign rdata_ext = (NIDX * 32)'(slv_tcipif_rdata);
    assign rdata_sel = rdata_ext[{idx_q, 5'd0} +: 32];
    assign done = (state == SEL || state == WAIT) && cmplt_ext[idx_q];
    // The count includes the current WAIT cycle, so expiry lands on the TIMEOUT_CYC-th WAIT cycle.
    assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;
    assign expire = state == WAIT && TIMEOUT_CYC != 0 && !rtu_yy_xx_dbgon && cnt_inc == TO_VAL;

    // Next-state decode for the transaction FSM.
    always_comb begin
        nxt = state;
        case (state)
            IDLE:      nxt = tcipif_bmu_dbus_grnt ? (err ? ERR : SEL) : IDLE;
            ERR:       nxt = RESP;
            SEL, WAIT: nxt = (done || expire) ? RESP : WAIT;
            RESP:      nxt = IDLE;
            default:   nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst)
            state <= IDLE;
        else
            state <= nxt;
    end

    // Timeout counter: cleared in SEL, counts saturating through WAIT.
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst || state == SEL)
            cnt <= '0;
        else if (state == WAIT)
            cnt <= cnt_inc;
    end

    // Slave bus: capture the accepted request and pulse the select for one cycle.
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            tcipif_slv_sel  <= '0;
            idx_q           <= '0;
            tcipif_xx_addr  <= '0;
            tcipif_xx_write <= 1'b0;
            tcipif_xx_wdata <= '0;
            tcipif_xx_size  <= '0;
        end else begin
            tcipif_slv_sel <= (tcipif_bmu_dbus_grnt && !err) ? NUM_SLV'(1) << idx : '0;
            if (tcipif_bmu_dbus_grnt && !err) begin
                idx_q           <= idx;
                tcipif_xx_addr  <= bmu_tcipif_dbus_addr[WIN_LOG2-1:0];
                tcipif_xx_write <= bmu_tcipif_dbus_write;
                tcipif_xx_wdata <= bmu_tcipif_dbus_wdata;
                tcipif_xx_size  <= bmu_tcipif_dbus_size;
            end
        end
    end

    // BMU response: one-cycle completion; error unless a slave completion was taken.
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            tcipif_bmu_dbus_trans_cmplt <= 1'b0;
            tcipif_bmu_dbus_acc_err     <= 1'b0;
            tcipif_bmu_dbus_data        <= '0;
        end else begin
            tcipif_bmu_dbus_trans_cmplt <= nxt == RESP;
            tcipif_bmu_dbus_acc_err     <= nxt == RESP && !done;
            tcipif_bmu_dbus_data        <= (nxt == RESP && done && !tcipif_xx_write) ? rdata_sel : '0;
        end
    end
endmodule

// File: tb/tb_pa_tcipif_nslv_bridge.sv
// tb_pa_tcipif_nslv_bridge: directed self-checking bench for the TCIP slave bridge
module tb_pa_tcipif_nslv_bridge;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  base = 32'hE000_0000;
    logic         dbgon = 1'b0;
    logic         req = 1'b0;
    logic [31:0]  addr = '0;
    logic         write = 1'b0;
    logic [31:0]  wdata = '0;
    logic [1:0]   size = '0;
    logic         supv = 1'b1;
    logic         deny = 1'b0;
    logic         grnt, trans_cmplt, acc_err;
    logic [31:0]  data;
    logic [3:0]   sel;
    logic [11:0]  xx_addr;
    logic         xx_write;
    logic [31:0]  xx_wdata;
    logic [1:0]   xx_size;
    logic [3:0]   slv_cmplt = '0;
    logic [127:0] slv_rdata = {32'h3333_3333, 32'h2222_2222, 32'hA5A5_0001, 32'h0000_CAFE};
    int           ncmp = 0;
    int           nerr = 0;

    pa_tcipif_nslv_bridge dut (
        .forever_cpuclk(clk),
        .cpurst(rst),
        .pad_cpu_tcip_base(base),
        .rtu_yy_xx_dbgon(dbgon),
        .bmu_tcipif_dbus_req(req),
        .bmu_tcipif_dbus_addr(addr),
        .bmu_tcipif_dbus_write(write),
        .bmu_tcipif_dbus_wdata(wdata),
        .bmu_tcipif_dbus_size(size),
        .bmu_tcipif_dbus_supv_mode(supv),
        .bmu_tcipif_dbus_acc_deny(deny),
        .tcipif_bmu_dbus_grnt(grnt),
        .tcipif_bmu_dbus_trans_cmplt(trans_cmplt),
        .tcipif_bmu_dbus_acc_err(acc_err),
        .tcipif_bmu_dbus_data(data),
        .tcipif_slv_sel(sel),
        .tcipif_xx_addr(xx_addr),
        .tcipif_xx_write(xx_write),
        .tcipif_xx_wdata(xx_wdata),
        .tcipif_xx_size(xx_size),
        .slv_tcipif_cmplt(slv_cmplt),
        .slv_tcipif_rdata(slv_rdata)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One transaction from grant to one cycle past completion. inj: cycle after grant at which
    // the target slave pulses cmplt (-1 = never); lat: cycle after grant where trans_cmplt is expected.
    task automatic txn(input string tag, input logic [31:0] a, input logic wr, input logic [31:0] wd,
                       input logic [1:0] sz, input logic sv, input logic dbg, input logic dn,
                       input logic [3:0] tgt, input int inj, input int lat,
                       input logic exp_err, input logic [3:0] exp_sel, input logic [31:0] exp_data);
        logic early = 1'b0;
        logic stray = 1'b0;
        addr = a; write = wr; wdata = wd; size = sz; supv = sv; dbgon = dbg; deny = dn; req = 1'b1;
        #1;
        chk({tag, ".grnt"}, 32'(grnt), 32'd1);
        for (int k = 1; k <= lat; k++) begin
            tick;
            req = 1'b0;
            slv_cmplt = (k == inj) ? tgt : 4'b0000;
            if (k == 1) begin
                chk({tag, ".sel"}, 32'(sel), 32'(exp_sel));
                if (!exp_err) begin
                    chk({tag, ".xx_addr"}, 32'(xx_addr), 32'(a[11:0]));
                    chk({tag, ".xx_write"}, 32'(xx_write), 32'(wr));
                    chk({tag, ".xx_wdata"}, xx_wdata, wd);
                    chk({tag, ".xx_size"}, 32'(xx_size), 32'(sz));
                end
            end else if (sel != 4'b0000) stray = 1'b1;
            if (k < lat && trans_cmplt) early = 1'b1;
        end
        chk({tag, ".early_cmplt"}, 32'(early), 32'd0);
        chk({tag, ".stray_sel"}, 32'(stray), 32'd0);
        chk({tag, ".cmplt"}, 32'(trans_cmplt), 32'd1);
        chk({tag, ".acc_err"}, 32'(acc_err), 32'(exp_err));
        chk({tag, ".data"}, data, exp_data);
        tick;
        chk({tag, ".cmplt_off"}, 32'(trans_cmplt), 32'd0);
        chk({tag, ".data_off"}, data, 32'd0);
        supv = 1'b1; dbgon = 1'b0; deny = 1'b0;
    endtask

    initial begin
        tick;
        tick;
        chk("rst.cmplt", 32'(trans_cmplt), 32'd0);
        chk("rst.err", 32'(acc_err), 32'd0);
        chk("rst.data", data, 32'd0);
        chk("rst.sel", 32'(sel), 32'd0);
        chk("rst.xx", {xx_addr, xx_write, xx_size, 17'd0}, 32'd0);
        chk("rst.wdata", xx_wdata, 32'd0);
        rst = 1'b0;
        tick;
        txn("rd_s1", 32'hE000_1004, 1'b0, 32'd0, 2'd2, 1'b1, 1'b0, 1'b0, 4'b0010, 2, 3, 1'b0, 4'b0010, 32'hA5A5_0001);
        txn("wr_s3", 32'hE000_3008, 1'b1, 32'h1234_5678, 2'd2, 1'b1, 1'b0, 1'b0, 4'b1000, 1, 2, 1'b0, 4'b1000, 32'd0);
        chk("wr_s3.hold_write", 32'(xx_write), 32'd1);
        chk("wr_s3.hold_wdata", xx_wdata, 32'h1234_5678);
        txn("half_mis", 32'hE000_0001, 1'b0, 32'd0, 2'd1, 1'b1, 1'b0, 1'b0, 4'b0001, 1, 2, 1'b1, 4'b0000, 32'd0);
        txn("size3", 32'hE000_1000, 1'b0, 32'd0, 2'd3, 1'b1, 1'b0, 1'b0, 4'b0010, 1, 2, 1'b1, 4'b0000, 32'd0);
        txn("miss", 32'hF000_0000, 1'b0, 32'd0, 2'd2, 1'b1, 1'b0, 1'b0, 4'b0001, 1, 2, 1'b1, 4'b0000, 32'd0);
        txn("deny", 32'hE000_1000, 1'b0, 32'd0, 2'd2, 1'b1, 1'b0, 1'b1, 4'b0010, 1, 2, 1'b1, 4'b0000, 32'd0);
        txn("word_mis", 32'hE000_1002, 1'b0, 32'd0, 2'd2, 1'b1, 1'b0, 1'b0, 4'b0010, 1, 2, 1'b1, 4'b0000, 32'd0);
        txn("mpriv", 32'hE000_0000, 1'b0, 32'd0, 2'd2, 1'b0, 1'b0, 1'b0, 4'b0001, 1, 2, 1'b1, 4'b0000, 32'd0);
        txn("mpriv_dbg", 32'hE000_0000, 1'b0, 32'd0, 2'd2, 1'b0, 1'b1, 1'b0, 4'b0001, 1, 2, 1'b0, 4'b0001, 32'h0000_CAFE);
        txn("byte_s2", 32'hE000_2003, 1'b0, 32'd0, 2'd0, 1'b0, 1'b0, 1'b0, 4'b0100, 3, 4, 1'b0, 4'b0100, 32'h2222_2222);
        txn("timeout", 32'hE000_2000, 1'b0, 32'd0, 2'd2, 1'b1, 1'b0, 1'b0, 4'b0100, -1, 257, 1'b1, 4'b0100, 32'd0);
        slv_cmplt = 4'b0100;
        tick;
        slv_cmplt = 4'b0000;
        chk("late_cmplt.ignored", 32'(trans_cmplt), 32'd0);
        tick;
        chk("late_cmplt.quiet", 32'(trans_cmplt), 32'd0);
        txn("expiry_win", 32'hE000_2000, 1'b0, 32'd0, 2'd2, 1'b1, 1'b0, 1'b0, 4'b0100, 256, 257, 1'b0, 4'b0100, 32'h2222_2222);
        addr = 32'hE000_2010; write = 1'b1; wdata = 32'hDEAD_BEEF; size = 2'd2; req = 1'b1;
        tick;
        req = 1'b0;
        chk("rstmid.sel", 32'(sel), 32'b0100);
        tick;
        tick;
        rst = 1'b1;
        req = 1'b1;
        #1;
        chk("rstmid.grnt_in_rst", 32'(grnt), 32'd0);
        tick;
        chk("rstmid.cmplt", 32'(trans_cmplt), 32'd0);
        chk("rstmid.sel0", 32'(sel), 32'd0);
        chk("rstmid.xx", {xx_addr, xx_write, xx_size, 17'd0}, 32'd0);
        chk("rstmid.wdata", xx_wdata, 32'd0);
        chk("rstmid.err_data", {31'd0, acc_err} | data, 32'd0);
        rst = 1'b0;
        req = 1'b0;
        txn("post_rst", 32'hE000_1004, 1'b0, 32'd0, 2'd2, 1'b1, 1'b0, 1'b0, 4'b0010, 1, 2, 1'b0, 4'b0010, 32'hA5A5_0001);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/pa_tcipif_nslv_bridge.md
Name: pa_tcipif_nslv_bridge

Overview:
- Parametrised successor to the fixed three-target TCIP decode.
- Accepts one data-bus transaction at a time from the BMU and decodes it against a programmable TCIP base into NUM_SLV equal-sized slave windows.
- Drives a shared registered slave bus and returns read data, completion and access error to the BMU.
- Adds behaviour the fixed decode lacks: per-slave machine-mode protection, alignment/size checking, and a per-transaction completion timeout that converts a hung slave into an error response.

Parameters:
- NUM_SLV, 4, number of slave windows (2..16).
- WIN_LOG2, 12, log2 of bytes per slave window.
- TIMEOUT_W, 8, width of the timeout counter.
- TIMEOUT_CYC, 255, WAIT cycles before error; 0 disables the timeout.
- MPRIV_MASK, 4'b0011, bit i=1 means slave i rejects non-machine (supv_mode=0) access.

Ports:
- forever_cpuclk  in  1  clock.
- cpurst  in  1  synchronous active-high reset.
- pad_cpu_tcip_base  in  32  TCIP region base, quasi-static.
- rtu_yy_xx_dbgon  in  1  debug mode: bypasses MPRIV check and timeout.
- bmu_tcipif_dbus_req  in  1  request valid.
- bmu_tcipif_dbus_addr  in  32  byte address.
- bmu_tcipif_dbus_write  in  1  1=write.
- bmu_tcipif_dbus_wdata  in  32  write data.
- bmu_tcipif_dbus_size  in  2  0=byte, 1=half, 2=word, 3=illegal.
- bmu_tcipif_dbus_supv_mode  in  1  1=machine-privileged access.
- bmu_tcipif_dbus_acc_deny  in  1  upstream PMP deny.
- tcipif_bmu_dbus_grnt  out  1  request accepted this cycle.
- tcipif_bmu_dbus_trans_cmplt  out  1  one-cycle completion pulse.
- tcipif_bmu_dbus_acc_err  out  1  error qualifier, valid with cmplt.
- tcipif_bmu_dbus_data  out  32  read data, valid with cmplt.
- tcipif_slv_sel  out  NUM_SLV  one-hot slave select, one-cycle pulse.
- tcipif_xx_addr  out  WIN_LOG2  offset within window.
- tcipif_xx_write  out  1  registered write flag.
- tcipif_xx_wdata  out  32  registered write data.
- tcipif_xx_size  out  2  registered size.
- slv_tcipif_cmplt  in  NUM_SLV  per-slave completion pulse.
- slv_tcipif_rdata  in  NUM_SLV*32  per-slave read data; slave i occupies bits [32i+31:32i].

Behaviour:
- Clocking and reset: single clock; all state updates on the rising edge. Reset is synchronous, active-high.
- Reset values: state=IDLE; tcipif_slv_sel, tcipif_xx_addr, tcipif_xx_write, tcipif_xx_wdata, tcipif_xx_size, trans_cmplt, acc_err and data are all 0.
- Grant: grnt = req & (state==IDLE) & ~cpurst, combinational. Requests are never accepted in any other state. The BMU must hold req until granted.
- Decode at grant:
  - idx = addr[WIN_LOG2 +: IDX_W], where IDX_W = clog2(NUM_SLV).
  - hit = addr[31:WIN_LOG2+IDX_W] == pad_cpu_tcip_base[31:WIN_LOG2+IDX_W], and idx < NUM_SLV.
- Error conditions at grant (any one set): acc_deny; ~hit; size==3; size==1 & addr[0]; size==2 & addr[1:0]!=0; MPRIV_MASK[idx] & ~supv_mode & ~dbgon.
- FSM:
  - IDLE: on grant with an error → ERR. On grant without error → SEL, capturing idx, addr[WIN_LOG2-1:0], write, wdata, size.
  - ERR (1 cycle) → RESP with acc_err=1, data=0. No slave sel is ever asserted.
  - SEL (1 cycle): tcipif_slv_sel[idx]=1; timeout counter cleared → WAIT.
  - WAIT: sel=0; xx_addr/write/wdata/size are held stable until RESP. When slv_tcipif_cmplt[idx] is sampled, capture rdata (write → data=0), set acc_err=0, and go → RESP.
  - RESP (1 cycle): trans_cmplt=1, with acc_err and data valid → IDLE. data returns to 0 the following cycle.
- Completion sampling: slave cmplt is sampled in SEL as well as WAIT. A cmplt coincident with the sel pulse goes SEL→RESP directly.
- Latency: minimum 2 cycles from grant to trans_cmplt (grant T, sel T+1, cmplt T+1, RESP T+2). Error path is also exactly 2 cycles.
- Timeout:
  - Counter increments each WAIT cycle.
  - When count==TIMEOUT_CYC and there is no cmplt, go → RESP with acc_err=1, data=0.
  - cmplt in the same cycle as expiry wins: normal response.
  - The counter saturates and never wraps.
  - Disabled when TIMEOUT_CYC==0 or dbgon=1.
- Stray completions: slv_tcipif_cmplt on a non-selected index, or in any state other than SEL/WAIT, is ignored.
- A slave completing after its timeout has already been reported is ignored.
- Reset mid-transaction: return to IDLE next edge; no trans_cmplt is issued for the dropped transaction.

Test Plan:
- base=0xE000_0000, word read 0xE000_1004, slave1 cmplt at first WAIT cycle with rdata 0xA5A5_0001 → grnt T; sel=4'b0010, xx_addr=0x004 at T+1; cmplt T+3; data=0xA5A5_0001, acc_err=0.
- Word write 0xE000_3008 wdata 0x1234_5678, slave3 cmplt coincident with sel → sel=4'b1000, xx_write=1, xx_wdata=0x1234_5678; cmplt at T+2; data=0; acc_err=0.
- Half read 0xE000_0001; then size=3; then addr 0xF000_0000; then acc_deny=1 → each: trans_cmplt at T+2 with acc_err=1, data=0, no sel ever asserted.
- supv_mode=0 access to slave0 (MPRIV_MASK bit0=1) → acc_err=1, no sel. Same access with dbgon=1 → normal access and completion.
- Slave2 never completes, TIMEOUT_CYC=255 → acc_err=1 exactly 255 WAIT cycles after sel. A late cmplt is ignored. Repeat with cmplt on the expiry cycle → acc_err=0.
- cpurst asserted in WAIT → IDLE next cycle, all outputs 0, no cmplt. A new request is granted the first cycle after reset is released.
